// File: rtl/mips_mem_responder_pkg.sv
`default_nettype none
// ==========================================================================
// mips_mem_responder_pkg: boot states and address helpers for the responder
// Rev 1.0
// ==========================================================================
package mips_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PAD   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_RUN   = 2'd3
  } boot_state_t;

  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Byte address is usable only if word aligned and inside the array.
  function automatic logic word_valid(input logic [31:0] addr, input int unsigned words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mem_responder_boot_fsm.sv
`default_nettype none
// ==========================================================================
// mem_boot_fsm: sequences program load, IMEM pad, DMEM clear, core release
// Rev 1.0
// ==========================================================================
module mem_boot_fsm
  import mips_mem_responder_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DMEM_WORDS = 256,
  parameter int unsigned PW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic          ld_last,
  output boot_state_t   state,
  output logic [PW-1:0] ptr,
  output logic          ld_ready,
  output logic          cpu_reset,
  output logic          ld_overflow
);

  localparam logic [PW-1:0] IMEM_LAST = PW'(IMEM_WORDS - 1);
  localparam logic [PW-1:0] DMEM_LAST = PW'(DMEM_WORDS - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_LOAD;
      ptr         <= '0;
      ld_ready    <= 1'b1;
      cpu_reset   <= 1'b0;
      ld_overflow <= 1'b0;
    end else begin
      // Released one cycle after RUN is reached, so the last clear has landed.
      cpu_reset <= (state == ST_RUN);
      case (state)
        ST_LOAD: begin
          if (ld_valid && ld_ready) begin
            if (ptr == IMEM_LAST) begin
              ptr      <= '0;
              state    <= ST_CLEAR;
              ld_ready <= 1'b0;
              if (!ld_last) ld_overflow <= 1'b1;
            end else if (ld_last) begin
              ptr      <= ptr + PW'(1);
              state    <= ST_PAD;
              ld_ready <= 1'b0;
            end else begin
              ptr <= ptr + PW'(1);
            end
          end
        end
        ST_PAD: begin
          if (ptr == IMEM_LAST) begin
            ptr   <= '0;
            state <= ST_CLEAR;
          end else begin
            ptr <= ptr + PW'(1);
          end
        end
        ST_CLEAR: begin
          if (ptr == DMEM_LAST) begin
            ptr   <= '0;
            state <= ST_RUN;
          end else begin
            ptr <= ptr + PW'(1);
          end
        end
        ST_RUN: ;
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_mem_responder.sv
`default_nettype none
// ==========================================================================
// mips_mem_responder: IMEM/DMEM responder with boot loader for the MIPS core
// Rev 1.0
// ==========================================================================
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] NOP_WORD   = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] Instruction,
  input  logic [31:0] DataAddr,
  output logic [31:0] Data,
  input  logic [31:0] DataWrData,
  input  logic        DataWrEn,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_reset,
  output logic        inst_fault,
  output logic        data_fault,
  output logic        ld_overflow
);

  localparam int unsigned IW = $clog2(IMEM_WORDS);
  localparam int unsigned DW = $clog2(DMEM_WORDS);
  localparam int unsigned PW = (IW > DW) ? IW : DW;

  boot_state_t   state;
  logic [PW-1:0] ptr;
  logic [31:0]   imem [IMEM_WORDS];
  logic [31:0]   dmem [DMEM_WORDS];
  logic [IW-1:0] pc_idx;
  logic [DW-1:0] da_idx;
  logic          pc_ok;
  logic          da_ok;
  logic          run;
  logic          load_en;
  logic          store_en;

  mem_boot_fsm #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS),
    .PW         (PW)
  ) u_boot_fsm (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_last     (ld_last),
    .state       (state),
    .ptr         (ptr),
    .ld_ready    (ld_ready),
    .cpu_reset   (cpu_reset),
    .ld_overflow (ld_overflow)
  );

  assign pc_idx   = PC[IW+1:2];
  assign da_idx   = DataAddr[DW+1:2];
  assign pc_ok    = word_valid(PC, IMEM_WORDS);
  assign da_ok    = word_valid(DataAddr, DMEM_WORDS);
  assign run      = (state == ST_RUN);
  assign load_en  = (state == ST_LOAD) && ld_valid && ld_ready;
  assign store_en = run && DataWrEn && da_ok;

  // Asynchronous reads: a same-cycle store is visible only after the edge.
  assign Instruction = pc_ok ? imem[pc_idx] : NOP_WORD;
  assign Data        = da_ok ? dmem[da_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      if (load_en) begin
        imem[ptr[IW-1:0]] <= ld_data;
      end else if (state == ST_PAD) begin
        imem[ptr[IW-1:0]] <= NOP_WORD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == ST_CLEAR) begin
        dmem[ptr[DW-1:0]] <= 32'h0;
      end else if (store_en) begin
        dmem[da_idx] <= DataWrData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      inst_fault <= 1'b0;
      data_fault <= 1'b0;
    end else if (run) begin
      if (!pc_ok) inst_fault <= 1'b1;
      if (DataWrEn && !da_ok) data_fault <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
`default_nettype none
// ==========================================================================
// tb_mips_mem_responder: randomized bench with behavioural memory/boot model
// Rev 1.0
// ==========================================================================
module tb_mips_mem_responder;

  localparam int IMEM_WORDS = 128;
  localparam int DMEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] DataAddr = '0;
  logic [31:0] DataWrData = '0;
  logic        DataWrEn = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic [31:0] Instruction;
  logic [31:0] Data;
  logic        ld_ready;
  logic        cpu_reset;
  logic        inst_fault;
  logic        data_fault;
  logic        ld_overflow;

  mips_mem_responder #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS),
    .NOP_WORD   (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PC          (PC),
    .Instruction (Instruction),
    .DataAddr    (DataAddr),
    .Data        (Data),
    .DataWrData  (DataWrData),
    .DataWrEn    (DataWrEn),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .cpu_reset   (cpu_reset),
    .inst_fault  (inst_fault),
    .data_fault  (data_fault),
    .ld_overflow (ld_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: boot progress is tracked as "words loaded" plus "cycles since load ended".
  logic [31:0] m_imem [IMEM_WORDS];
  logic [31:0] m_dmem [DMEM_WORDS];
  int m_loaded = 0;
  int m_since = 0;
  bit m_done = 0, m_ovf = 0, m_if = 0, m_df = 0;

  function automatic bit addr_ok(input logic [31:0] a, input int words);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'(words));
  endfunction

  function automatic bit m_run();
    return m_done && (m_since >= (IMEM_WORDS - m_loaded) + DMEM_WORDS);
  endfunction

  function automatic bit m_cpu();
    return m_done && (m_since >= (IMEM_WORDS - m_loaded) + DMEM_WORDS + 1);
  endfunction

  always @(posedge clk) begin : model
    if (!reset) begin
      m_loaded = 0; m_done = 0; m_since = 0;
      m_ovf = 0; m_if = 0; m_df = 0;
    end else if (!m_done) begin
      if (ld_valid) begin
        m_imem[m_loaded] = ld_data;
        m_loaded++;
        if (ld_last || m_loaded == IMEM_WORDS) begin
          m_done  = 1;
          m_since = 0;
          m_ovf   = (ld_last == 1'b0);
          for (int i = m_loaded; i < IMEM_WORDS; i++) m_imem[i] = 32'h0;
          for (int i = 0; i < DMEM_WORDS; i++) m_dmem[i] = 32'h0;
        end
      end
    end else begin
      if (m_run()) begin
        if (!addr_ok(PC, IMEM_WORDS)) m_if = 1;
        if (DataWrEn) begin
          if (addr_ok(DataAddr, DMEM_WORDS)) m_dmem[DataAddr[9:2]] = DataWrData;
          else m_df = 1;
        end
      end
      m_since++;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] ei, ed;
    if (chk_en) begin
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, !m_done});
      chk("cpu_reset", {31'b0, cpu_reset}, {31'b0, m_cpu()});
      chk("ld_overflow", {31'b0, ld_overflow}, {31'b0, m_ovf});
      chk("inst_fault", {31'b0, inst_fault}, {31'b0, m_if});
      chk("data_fault", {31'b0, data_fault}, {31'b0, m_df});
      if (m_run()) begin
        ei = addr_ok(PC, IMEM_WORDS) ? m_imem[PC[8:2]] : 32'h0;
        ed = addr_ok(DataAddr, DMEM_WORDS) ? m_dmem[DataAddr[9:2]] : 32'h0;
        chk("Instruction", Instruction, ei);
        chk("Data", Data, ed);
      end
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; DataWrEn = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic rand_core_inputs();
    PC = ($urandom % 16 == 0) ? $urandom : {23'b0, 7'($urandom), 2'b00};
    DataAddr = ($urandom % 16 == 0) ? $urandom : {22'b0, 8'($urandom), 2'b00};
    DataWrData = $urandom;
    DataWrEn = ($urandom % 3 == 0);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      rand_core_inputs();
      ld_valid = ($urandom % 4 == 0);
      ld_data  = $urandom;
      ld_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0; DataWrEn = 1'b0; PC = '0;
  endtask

  task automatic random_boot(input int n_words);
    int cnt = 0;
    int cyc = 0;
    while (!cpu_reset && cyc < 2000) begin
      rand_core_inputs();
      if (cnt < n_words && ($urandom % 2 == 1)) begin
        ld_valid = 1'b1; ld_data = $urandom; ld_last = (cnt == n_words - 1);
        cnt++;
      end else begin
        ld_valid = 1'b0; ld_last = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ld_valid = 1'b0; ld_last = 1'b0; DataWrEn = 1'b0; PC = '0;
    chk("boot_done", {31'b0, cpu_reset}, 32'd1);
  endtask

  initial begin
    logic [31:0] w [4];
    int cyc;
    #1;
    do_reset(2);
    chk_en = 1'b1;
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    chk("rst_overflow", {31'b0, ld_overflow}, 32'd0);

    // Four words back to back: release expected after 4+124+256+1 edges.
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    cyc = 0;
    while (!cpu_reset && cyc < 1000) begin
      if (cyc < 4) begin
        ld_valid = 1'b1; ld_data = w[cyc]; ld_last = (cyc == 3);
      end else begin
        ld_valid = 1'b0; ld_last = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("boot_latency", 32'(cyc), 32'd385);
    for (int i = 0; i < 4; i++) begin
      PC = 32'(i * 4);
      #1 chk("imem_loaded", Instruction, w[i]);
    end
    PC = 32'h10;  #1 chk("imem_pad_lo", Instruction, 32'h0);
    PC = 32'h1FC; #1 chk("imem_pad_hi", Instruction, 32'h0);
    PC = '0;

    @(posedge clk); #1;
    DataAddr = 32'h40; DataWrData = 32'hDEADBEEF; DataWrEn = 1'b1;
    #1 chk("rdw_old", Data, 32'h0);
    @(posedge clk); #1;
    DataWrEn = 1'b0;
    #1 chk("rdw_new", Data, 32'hDEADBEEF);
    PC = 32'h202;
    #1 chk("pc_bad_inst", Instruction, 32'h0);
    @(posedge clk); #1;
    chk("inst_fault_set", {31'b0, inst_fault}, 32'd1);
    PC = '0;
    DataAddr = 32'h401; DataWrData = 32'h1234_5678; DataWrEn = 1'b1;
    @(posedge clk); #1;
    DataWrEn = 1'b0;
    chk("data_fault_set", {31'b0, data_fault}, 32'd1);
    DataAddr = 32'h0;
    #1 chk("dmem_keep", Data, 32'h0);

    run_random(200);

    // 128 words without ld_last, then reset during CLEAR at ptr 100.
    do_reset(1);
    for (int i = 0; i < IMEM_WORDS; i++) begin
      ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    chk("ovf_flag", {31'b0, ld_overflow}, 32'd1);
    chk("ovf_ready", {31'b0, ld_ready}, 32'd0);
    repeat (100) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midclr_ready", {31'b0, ld_ready}, 32'd1);
    chk("midclr_cpu", {31'b0, cpu_reset}, 32'd0);
    chk("midclr_ovf", {31'b0, ld_overflow}, 32'd0);

    random_boot($urandom_range(1, 127));
    run_random(150);
    do_reset(1);
    random_boot(128);
    run_random(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
